// File: rtl/rx_iq_pkg.sv
// Shared definitions for the RX I/Q decimation slice: default widths,
// the 4-component antenna bundle and the filter rounding constant.
package rx_iq_pkg;

   localparam int IQ_W_DEFAULT    = 16;
   localparam int GAP_MAX_DEFAULT = 64;
   localparam int CNT_W_DEFAULT   = 16;
   localparam int GAP_CNT_W       = 8;
   localparam int ROUND_CONST     = 2;

   typedef struct packed {
      logic signed [IQ_W_DEFAULT-1:0] i0;
      logic signed [IQ_W_DEFAULT-1:0] q0;
      logic signed [IQ_W_DEFAULT-1:0] i1;
      logic signed [IQ_W_DEFAULT-1:0] q1;
   } iq_bundle_t;

endpackage

// File: rtl/rx_iq_decim2_if.sv
// Sample bus between the RF capture logic (master) and the decimator (slave).
interface rx_iq_decim2_if
   import rx_iq_pkg::*;
#(
   parameter int IQ_DATA_WIDTH = IQ_W_DEFAULT,
   parameter int CNT_WIDTH     = CNT_W_DEFAULT
);
   logic signed [IQ_DATA_WIDTH-1:0] adc_i0, adc_q0, adc_i1, adc_q1;
   logic                            adc_valid;
   logic                            decim_phase;
   logic                            bypass;
   logic                            gap_err_clr;
   logic signed [IQ_DATA_WIDTH-1:0] bw20_i0, bw20_q0, bw20_i1, bw20_q1;
   logic                            bw20_iq_valid;
   logic                            gap_err;
   logic [CNT_WIDTH-1:0]            out_cnt;

   modport master (
      output adc_i0, adc_q0, adc_i1, adc_q1, adc_valid,
      output decim_phase, bypass, gap_err_clr,
      input  bw20_i0, bw20_q0, bw20_i1, bw20_q1, bw20_iq_valid,
      input  gap_err, out_cnt
   );

   modport slave (
      input  adc_i0, adc_q0, adc_i1, adc_q1, adc_valid,
      input  decim_phase, bypass, gap_err_clr,
      output bw20_i0, bw20_q0, bw20_i1, bw20_q1, bw20_iq_valid,
      output gap_err, out_cnt
   );
endinterface

// File: rtl/rx_iq_fir121.sv
// Single-component [1 2 1]/4 low-pass: two-deep sample history plus a
// round-half-up output. The result is combinational; the caller registers it.
module rx_iq_fir121
   import rx_iq_pkg::*;
#(
   parameter int W = IQ_W_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                accept,
   input  logic                flush,
   input  logic signed [W-1:0] x,
   output logic signed [W-1:0] y
);

   logic signed [W-1:0] hist1;
   logic signed [W-1:0] hist2;
   logic signed [W+1:0] acc;
   logic signed [W+1:0] rounded;

   // Two guard bits hold 4*full-scale, so the rounded quarter always fits W.
   always_comb begin
      acc     = (W+2)'(hist2) + ((W+2)'(hist1) <<< 1) + (W+2)'(x);
      rounded = acc + (W+2)'(ROUND_CONST);
      y       = W'(rounded >>> 2);
   end

   // Shift history on each accepted sample; a flush wipes it so stale data never mixes in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist1 <= '0;
         hist2 <= '0;
      end else if (flush) begin
         hist1 <= '0;
         hist2 <= '0;
      end else if (accept) begin
         hist2 <= hist1;
         hist1 <= x;
      end
   end

endmodule

// File: rtl/rx_iq_decim2.sv
// 40 -> 20 Msps dual-antenna I/Q decimator with [1 2 1]/4 low-pass,
// bypass mode and an input-gap monitor that restarts the filter after stalls.
module rx_iq_decim2
   import rx_iq_pkg::*;
#(
   parameter int IQ_DATA_WIDTH = IQ_W_DEFAULT,
   parameter int GAP_MAX       = GAP_MAX_DEFAULT,
   parameter int CNT_WIDTH     = CNT_W_DEFAULT
) (
   input logic           clk,
   input logic           rst,
   rx_iq_decim2_if.slave bus
);

   localparam logic [GAP_CNT_W-1:0] GAP_TOP  = GAP_CNT_W'(GAP_MAX);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_MAX - 1);

   logic [1:0]                      n_cnt;
   logic                            parity;
   logic                            phase_lat;
   logic                            bypass_d;
   logic [GAP_CNT_W-1:0]            gap_cnt;
   logic                            gap_err_r;
   logic [CNT_WIDTH-1:0]            cnt_r;
   logic                            valid_r;
   logic signed [IQ_DATA_WIDTH-1:0] x_in  [4];
   logic signed [IQ_DATA_WIDTH-1:0] y_flt [4];
   logic signed [IQ_DATA_WIDTH-1:0] y_reg [4];

   logic gap_flush;
   logic byp_flush;
   logic flush;
   logic accept;
   logic fire;
   logic emit;

   assign x_in[0] = bus.adc_i0;
   assign x_in[1] = bus.adc_q0;
   assign x_in[2] = bus.adc_i1;
   assign x_in[3] = bus.adc_q1;

   // A new sample in the threshold cycle keeps the stream alive, so it beats the gap flush.
   always_comb begin
      gap_flush = !bus.adc_valid && (n_cnt != 2'd0) && (gap_cnt == GAP_LAST);
      byp_flush = bus.bypass != bypass_d;
      flush     = gap_flush || byp_flush;
      accept    = bus.adc_valid && !flush;
      fire      = accept && n_cnt[1] && (parity != phase_lat);
      emit      = bus.bypass ? bus.adc_valid : fire;
   end

   for (genvar c = 0; c < 4; c++) begin : g_fir
      rx_iq_fir121 #(.W(IQ_DATA_WIDTH)) u_fir (
         .clk    (clk),
         .rst    (rst),
         .accept (accept),
         .flush  (flush),
         .x      (x_in[c]),
         .y      (y_flt[c])
      );
   end

   // Sample index, parity, phase latch and the gap counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_cnt     <= 2'd0;
         parity    <= 1'b0;
         phase_lat <= bus.decim_phase;
         bypass_d  <= 1'b0;
         gap_cnt   <= '0;
      end else begin
         bypass_d <= bus.bypass;
         if (bus.adc_valid) begin
            gap_cnt <= '0;
         end else if (gap_cnt != GAP_TOP) begin
            gap_cnt <= gap_cnt + 1'b1;
         end
         if (flush) begin
            n_cnt     <= 2'd0;
            parity    <= 1'b0;
            phase_lat <= bus.decim_phase;
         end else if (accept) begin
            if (n_cnt != 2'd3) begin
               n_cnt <= n_cnt + 2'd1;
            end
            parity <= ~parity;
         end
      end
   end

   // Registered output samples, one-cycle strobe and the wrapping strobe counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= 1'b0;
         cnt_r   <= '0;
         for (int c = 0; c < 4; c++) begin
            y_reg[c] <= '0;
         end
      end else begin
         valid_r <= emit;
         if (emit) begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
            for (int c = 0; c < 4; c++) begin
               y_reg[c] <= bus.bypass ? x_in[c] : y_flt[c];
            end
         end
      end
   end

   // Sticky gap error; a fresh flush outranks a clear in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_err_r <= 1'b0;
      end else if (gap_flush) begin
         gap_err_r <= 1'b1;
      end else if (bus.gap_err_clr) begin
         gap_err_r <= 1'b0;
      end
   end

   assign bus.bw20_i0       = y_reg[0];
   assign bus.bw20_q0       = y_reg[1];
   assign bus.bw20_i1       = y_reg[2];
   assign bus.bw20_q1       = y_reg[3];
   assign bus.bw20_iq_valid = valid_r;
   assign bus.gap_err       = gap_err_r;
   assign bus.out_cnt       = cnt_r;

endmodule
